bsg_fork3_buffered: RTL and testbench
=====================================

Name: bsg_fork3_buffered

Overview:
- Takes one valid/ready stream of width_p-bit words and delivers every word to three independent consumers (branches 0, 1, 2).
- Each branch may accept on a different cycle. A branch never sees the same word twice, and the word is retired only once all three branches have taken it.
- Sits at the split point where one datapath feeds three parallel bitwise/logic lanes, as the one-to-three counterpart of the three-to-one reduction cells.

Parameters:
- width_p, 16, data word width in bits (legal range 1 and up).
- invert_p, 0, when 1 each branch output carries the bitwise complement of the stored word (~data); when 0 it carries the word unchanged.

Ports:
- clk_i  input  1  single clock, all state on rising edge.
- reset_n_i  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised externally.
- v_i  input  1  upstream word valid.
- data_i  input  width_p  upstream word.
- ready_o  output  1  block can accept a word this cycle.
- v_o  output  3  per-branch valid; bit k belongs to branch k.
- data_o  output  3*width_p  per-branch data; branch k occupies bits [k*width_p +: width_p].
- yumi_i  input  3  per-branch consume; bit k is legal only when v_o[k] is 1.

Behaviour:
- State: data_r (width_p bits) and pend_r (3-bit mask of branches still owed the current word).
- Reset (reset_n_i=0, asynchronous): pend_r=3'b000 and data_r=0. While in reset and after it: v_o=3'b000, data_o=0 (or all ones when invert_p=1), ready_o=1 once reset is released.
- Outputs:
  - v_o = pend_r.
  - data_o[k] = data_r, or ~data_r when invert_p=1; all three lanes are driven identically regardless of pend_r.
- Pending-drain term: done = (pend_r & ~yumi_i) == 0, i.e. every owed branch is either already served or consuming this cycle.
- ready_o = done. This gives a combinational path yumi_i -> ready_o and is the documented behaviour.
- Accept: when v_i & ready_o, then data_r <= data_i and pend_r <= 3'b111 on the next edge. Latency is one cycle: v_o = 3'b111 on the cycle after acceptance.
- Drain: when no accept occurs, pend_r <= pend_r & ~yumi_i, and data_r holds.
- Simultaneous final consume and new accept: the new word loads and pend_r=3'b111. The result is full throughput of one word per cycle when all branches consume every cycle.
- Idle: when v_i=0 and pend_r=0, state holds.
- Protocol violation: yumi_i[k]=1 while pend_r[k]=0 is illegal. The bench flags it with an assertion. The RTL masks it (yumi_i & pend_r) so state is never corrupted.
- Stall: a branch that never consumes blocks the block indefinitely and ready_o stays 0. There is no timeout.
- Reset mid-operation: any partially delivered word is discarded and pend_r clears immediately, without waiting for a clock edge.
- Ordering: every branch receives words in input order with no loss or duplication.
- Width and invert rules are purely bitwise; no arithmetic is performed.

Decomposition:
- Shared package bsg_fork_pkg holds:
  - localparam fork_ways_lp = 3.
  - typedef branch_mask_t logic [fork_ways_lp-1:0].
- One natural sub-module: bsg_fork_pend_tracker. It holds pend_r, computes the masked yumi and done, and is instantiated once with the ways parameter.
- The data register and invert lanes stay in the top module.

Test Plan:
- Reset then idle: reset_n_i pulse low mid-cycle -> v_o=000 and ready_o=1 immediately after reset is released; data_o=16'h0000 (invert_p=0).
- Lockstep full rate: v_i=1 with data_i=16'h0001, 0002, 0003 on consecutive cycles, yumi_i=111 whenever v_o=111 -> each branch sees 1, 2, 3 one cycle later; ready_o stays 1; no bubbles.
- Staggered consume: accept 16'hA5A5; yumi_i=001, then 100, then 010 on successive cycles -> v_o goes 111, 110, 010, 000; ready_o is 0 until the cycle branch 1 consumes; the next word loads on that edge.
- Stalled branch: branch 2 holds yumi_i[2]=0 for 10 cycles while v_i=1 -> data_o unchanged at 16'h1234; ready_o=0 throughout; v_o=100 after branches 0 and 1 consume.
- Invert mode (invert_p=1): accept 16'h00FF -> all three lanes show 16'hFF00; reset clears lanes to 16'hFFFF.
- Reset during partial delivery: pend_r=101, assert reset_n_i=0 asynchronously -> v_o=000 within the same cycle; after release, the stale word never reappears and the next accepted word is delivered cleanly.

Source files
------------

// File: rtl/bsg_fork_pkg.sv
//------------------------------------------------------------------------------
// bsg_fork_pkg : shared fan-out width and branch mask type for the fork cells
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bsg_fork_pkg;

    localparam int fork_ways_lp = 3;

    typedef logic [fork_ways_lp-1:0] branch_mask_t;

endpackage

`default_nettype wire

// File: rtl/bsg_fork_pend_tracker.sv
//------------------------------------------------------------------------------
// bsg_fork_pend_tracker : per-branch "still owed" mask and drain detection
// Revision              : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bsg_fork_pend_tracker
    import bsg_fork_pkg::*;
#(
    parameter int ways_p = fork_ways_lp
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              accept_i,
    input  logic [ways_p-1:0] yumi_i,
    output logic [ways_p-1:0] pend_o,
    output logic              done_o
);

    logic [ways_p-1:0] pend_q;
    logic [ways_p-1:0] pend_d;
    logic [ways_p-1:0] yumi_masked;

    // Illegal consumes on already-served branches are dropped here.
    assign yumi_masked = yumi_i & pend_q;
    assign done_o      = ((pend_q & ~yumi_masked) == '0);
    assign pend_o      = pend_q;

    always_comb begin
        pend_d = pend_q & ~yumi_masked;
        if (accept_i) begin
            pend_d = '1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsg_fork3_buffered.sv
//------------------------------------------------------------------------------
// bsg_fork3_buffered : one-entry buffered fork of a valid/ready stream to three
//                      independently consuming branches, optional inversion
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bsg_fork3_buffered
    import bsg_fork_pkg::*;
#(
    parameter int width_p  = 16,
    parameter int invert_p = 0
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           v_i,
    input  logic [width_p-1:0]             data_i,
    output logic                           ready_o,
    output logic [fork_ways_lp-1:0]        v_o,
    output logic [fork_ways_lp*width_p-1:0] data_o,
    input  logic [fork_ways_lp-1:0]        yumi_i
);

    logic               accept;
    logic               done;
    logic [width_p-1:0] data_q;
    logic [width_p-1:0] data_d;
    logic [width_p-1:0] lane_data;
    branch_mask_t       pend;

    // ready depends combinationally on yumi_i so the last consume and the
    // next accept can share a cycle.
    assign ready_o = done;
    assign accept  = v_i & done;
    assign v_o     = pend;
    assign data_d  = accept ? data_i : data_q;

    bsg_fork_pend_tracker #(
        .ways_p (fork_ways_lp)
    ) u_pend (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .accept_i  (accept),
        .yumi_i    (yumi_i),
        .pend_o    (pend),
        .done_o    (done)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    generate
        if (invert_p != 0) begin : g_invert
            assign lane_data = ~data_q;
        end else begin : g_pass
            assign lane_data = data_q;
        end
    endgenerate

    generate
        for (genvar k = 0; k < fork_ways_lp; k++) begin : g_lane
            assign data_o[k*width_p +: width_p] = lane_data;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bsg_fork3_buffered.sv
//------------------------------------------------------------------------------
// tb_bsg_fork3_buffered : directed bench for the three-way buffered fork
// Revision              : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_fork3_buffered;

    localparam int W = 16;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          v_i;
    logic [W-1:0]  data_i;
    logic [2:0]    yumi_i;
    logic          ready_o,  ready_inv;
    logic [2:0]    v_o,      v_inv;
    logic [3*W-1:0] data_o,  data_inv;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    bsg_fork3_buffered #(.width_p(W), .invert_p(0)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i)
    );

    bsg_fork3_buffered #(.width_p(W), .invert_p(1)) dut_inv (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_inv),
        .v_o       (v_inv),
        .data_o    (data_inv),
        .yumi_i    (yumi_i)
    );

    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert ((yumi_i & ~v_o) == 3'b000)
                else $error("yumi_i %b on branch not pending (v_o %b)", yumi_i, v_o);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        data_i    = '0;
        yumi_i    = 3'b000;

        // Reset then idle
        #3;
        check_eq("rst_v", v_o, 3'b000);
        #19;
        reset_n_i = 1'b1;
        #1;
        check_eq("idle_v", v_o, 3'b000);
        check_eq("idle_ready", ready_o, 1'b1);
        check_eq("idle_data", data_o, {3{16'h0000}});
        check_eq("idle_data_inv", data_inv, {3{16'hFFFF}});
        cyc();
        settle();
        check_eq("idle_hold_v", v_o, 3'b000);

        // Lockstep full rate
        v_i = 1'b1; data_i = 16'h0001; yumi_i = 3'b000;
        settle();
        check_eq("ls_ready0", ready_o, 1'b1);
        cyc();
        data_i = 16'h0002; yumi_i = 3'b111;
        settle();
        check_eq("ls_v1", v_o, 3'b111);
        check_eq("ls_d1", data_o, {3{16'h0001}});
        check_eq("ls_ready1", ready_o, 1'b1);
        cyc();
        data_i = 16'h0003; yumi_i = 3'b111;
        settle();
        check_eq("ls_v2", v_o, 3'b111);
        check_eq("ls_d2", data_o, {3{16'h0002}});
        check_eq("ls_ready2", ready_o, 1'b1);
        cyc();
        v_i = 1'b0; yumi_i = 3'b111;
        settle();
        check_eq("ls_v3", v_o, 3'b111);
        check_eq("ls_d3", data_o, {3{16'h0003}});
        cyc();
        yumi_i = 3'b000;
        settle();
        check_eq("ls_drained", v_o, 3'b000);
        check_eq("ls_ready_end", ready_o, 1'b1);

        // Staggered consume
        v_i = 1'b1; data_i = 16'hA5A5;
        cyc();
        data_i = 16'hBEEF; yumi_i = 3'b001;
        settle();
        check_eq("st_v0", v_o, 3'b111);
        check_eq("st_ready0", ready_o, 1'b0);
        cyc();
        yumi_i = 3'b100;
        settle();
        check_eq("st_v1", v_o, 3'b110);
        check_eq("st_ready1", ready_o, 1'b0);
        check_eq("st_d1", data_o, {3{16'hA5A5}});
        cyc();
        yumi_i = 3'b010;
        settle();
        check_eq("st_v2", v_o, 3'b010);
        check_eq("st_ready2", ready_o, 1'b1);
        cyc();
        v_i = 1'b0; yumi_i = 3'b111;
        settle();
        check_eq("st_next_v", v_o, 3'b111);
        check_eq("st_next_d", data_o, {3{16'hBEEF}});
        cyc();
        yumi_i = 3'b000;
        settle();
        check_eq("st_drained", v_o, 3'b000);

        // Stalled branch 2
        v_i = 1'b1; data_i = 16'h1234;
        cyc();
        data_i = 16'h5555; yumi_i = 3'b011;
        settle();
        check_eq("stall_v0", v_o, 3'b111);
        check_eq("stall_ready0", ready_o, 1'b0);
        cyc();
        yumi_i = 3'b000;
        for (int i = 0; i < 10; i++) begin
            settle();
            check_eq("stall_v", v_o, 3'b100);
            check_eq("stall_ready", ready_o, 1'b0);
            check_eq("stall_d", data_o, {3{16'h1234}});
            cyc();
        end
        yumi_i = 3'b100;
        settle();
        check_eq("stall_release_ready", ready_o, 1'b1);
        cyc();
        v_i = 1'b0; yumi_i = 3'b111;
        settle();
        check_eq("stall_next_v", v_o, 3'b111);
        check_eq("stall_next_d", data_o, {3{16'h5555}});
        cyc();
        yumi_i = 3'b000;

        // Invert mode
        v_i = 1'b1; data_i = 16'h00FF;
        cyc();
        v_i = 1'b0; yumi_i = 3'b111;
        settle();
        check_eq("inv_d", data_inv, {3{16'hFF00}});
        check_eq("inv_v", v_inv, 3'b111);
        check_eq("pass_d", data_o, {3{16'h00FF}});
        cyc();
        yumi_i = 3'b000;

        // Reset during partial delivery
        v_i = 1'b1; data_i = 16'hCAFE;
        cyc();
        v_i = 1'b0; yumi_i = 3'b010;
        settle();
        check_eq("pr_v0", v_o, 3'b111);
        cyc();
        yumi_i = 3'b000;
        settle();
        check_eq("pr_v1", v_o, 3'b101);
        settle();
        reset_n_i = 1'b0;
        settle();
        check_eq("pr_async_v", v_o, 3'b000);
        check_eq("pr_async_d", data_o, {3{16'h0000}});
        check_eq("pr_async_inv", data_inv, {3{16'hFFFF}});
        @(negedge clk_i);
        reset_n_i = 1'b1;
        cyc();
        settle();
        check_eq("pr_post_v", v_o, 3'b000);
        check_eq("pr_post_ready", ready_o, 1'b1);
        check_eq("pr_post_d", data_o, {3{16'h0000}});
        v_i = 1'b1; data_i = 16'h7777;
        cyc();
        v_i = 1'b0; yumi_i = 3'b111;
        settle();
        check_eq("pr_new_v", v_o, 3'b111);
        check_eq("pr_new_d", data_o, {3{16'h7777}});
        cyc();
        yumi_i = 3'b000;
        settle();
        check_eq("pr_new_drained", v_o, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
